alu_operand_stage: RTL and testbench

- Registered, parametrised successor to the execute-stage operand muxing.
- Resolves forwarding internally from NUM_FWD producer ports, youngest first, instead of taking external forward controls.
- Selects both ALU operands and the store data, then registers them in a valid/ready output stage.
- Detects load-use hazards and applies backpressure; sits between the ID/EX register and the ALU.

---
 rtl/alu_operand_stage_pkg.sv | 9 +
 rtl/alu_operand_stage_fwd_select.sv | 31 +++
 rtl/alu_operand_stage.sv | 85 ++++++++
 tb/tb_alu_operand_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: operand-source encodings and the zero-register number
package alu_operand_stage_pkg;
  localparam logic [1:0] SRC1_REG  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;
  localparam logic       SRC2_REG  = 1'b0;
  localparam logic       SRC2_IMM  = 1'b1;
  localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// fwd_select: youngest-first forwarding match for one source operand
module fwd_select
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0]         addr,
  input  logic [WIDTH-1:0]           reg_data,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD-1:0]         fwd_pend,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0]   fwd_data,
  output logic [WIDTH-1:0]           data,
  output logic                       hit,
  output logic                       pend
);
  // Scan oldest to youngest so the lowest-index match is the last to write.
  always_comb begin
    data = reg_data;
    hit  = 1'b0;
    pend = 1'b0;
    for (int p = NUM_FWD - 1; p >= 0; p--)
      if (fwd_valid[p] && fwd_addr[p*RADDR_W +: RADDR_W] == addr && addr != RADDR_W'(ZERO_REG)) begin
        data = fwd_data[p*WIDTH +: WIDTH];
        hit  = 1'b1;
        pend = fwd_pend[p];
      end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwarding-resolved operand/store-data select into a valid/ready register
// Optional perf counters (o_Fwd_Count, o_Stall_Count) when ALU_OPSEL_PERF_CNT_EN is defined.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Valid,
  output logic                       o_In_Ready,
  input  logic                       i_Flush,
  input  logic [RADDR_W-1:0]         i_Rs1_Addr,
  input  logic [RADDR_W-1:0]         i_Rs2_Addr,
  input  logic [WIDTH-1:0]           i_Rs1,
  input  logic [WIDTH-1:0]           i_Rs2,
  input  logic [WIDTH-1:0]           i_Immediate,
  input  logic [WIDTH-1:0]           i_PC,
  input  logic [1:0]                 i_ALU_src1_Ctrl,
  input  logic                       i_ALU_src2_Ctrl,
  input  logic [NUM_FWD-1:0]         i_Fwd_Valid,
  input  logic [NUM_FWD-1:0]         i_Fwd_Pend,
  input  logic [NUM_FWD*RADDR_W-1:0] i_Fwd_Addr,
  input  logic [NUM_FWD*WIDTH-1:0]   i_Fwd_Data,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic [WIDTH-1:0]           o_Op1,
  output logic [WIDTH-1:0]           o_Op2,
  output logic [WIDTH-1:0]           o_Store_Data
`ifdef ALU_OPSEL_PERF_CNT_EN
  ,
  output logic [31:0]                o_Fwd_Count,
  output logic [31:0]                o_Stall_Count
`endif
);
  logic [WIDTH-1:0] rs1_val, rs2_val, op1_sel;
  logic hit1, hit2, pend1, pend2, use1, hazard, accept;
  fwd_select #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_fwd1 (
    .addr(i_Rs1_Addr), .reg_data(i_Rs1), .fwd_valid(i_Fwd_Valid), .fwd_pend(i_Fwd_Pend),
    .fwd_addr(i_Fwd_Addr), .fwd_data(i_Fwd_Data), .data(rs1_val), .hit(hit1), .pend(pend1)
  );
  fwd_select #(.WIDTH(WIDTH), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)) u_fwd2 (
    .addr(i_Rs2_Addr), .reg_data(i_Rs2), .fwd_valid(i_Fwd_Valid), .fwd_pend(i_Fwd_Pend),
    .fwd_addr(i_Fwd_Addr), .fwd_data(i_Fwd_Data), .data(rs2_val), .hit(hit2), .pend(pend2)
  );
  // Operand 2 always matters because store data is taken from the rs2 path.
  assign use1       = i_ALU_src1_Ctrl == SRC1_REG;
  assign hazard     = (use1 && hit1 && pend1) || (hit2 && pend2);
  assign o_In_Ready = (!o_Valid || i_Ready) && !hazard;
  assign accept     = i_Valid && o_In_Ready && !i_Flush;
  always_comb
    op1_sel = use1 ? rs1_val : i_ALU_src1_Ctrl == SRC1_PC ? i_PC : '0;
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Valid      <= 1'b0;
      o_Op1        <= '0;
      o_Op2        <= '0;
      o_Store_Data <= '0;
    end else if (i_Flush) begin
      o_Valid <= 1'b0;
    end else if (accept) begin
      o_Valid      <= 1'b1;
      o_Op1        <= op1_sel;
      o_Op2        <= i_ALU_src2_Ctrl == SRC2_IMM ? i_Immediate : rs2_val;
      o_Store_Data <= rs2_val;
    end else if (i_Ready) begin
      o_Valid <= 1'b0;
    end
  end
`ifdef ALU_OPSEL_PERF_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Fwd_Count   <= '0;
      o_Stall_Count <= '0;
    end else begin
      if (accept)
        o_Fwd_Count <= o_Fwd_Count + 32'(use1 && hit1) + 32'(hit2);
      if (i_Valid && hazard && !i_Flush)
        o_Stall_Count <= o_Stall_Count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed plus randomized checks against a behavioural operand-stage model
module tb_alu_operand_stage;
  localparam int W = 32, N = 2, A = 5;
  logic clk = 1'b0;
  logic rst, valid, flush, ready, in_ready, o_valid, s2;
  logic [1:0] s1;
  logic [A-1:0] rs1a, rs2a;
  logic [W-1:0] rs1, rs2, imm, pc, op1, op2, sd;
  logic fv[N], fp[N];
  logic [A-1:0] fa[N];
  logic [W-1:0] fd[N];
  logic [N-1:0] fvb, fpb;
  logic [N*A-1:0] fab;
  logic [N*W-1:0] fdb;
  logic m_valid;
  logic [W-1:0] m_op1, m_op2, m_sd;
  int pass = 0, total = 0;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign fvb[g] = fv[g];
    assign fpb[g] = fp[g];
    assign fab[g*A +: A] = fa[g];
    assign fdb[g*W +: W] = fd[g];
  end
  always #5 clk = ~clk;
  alu_operand_stage #(.WIDTH(W), .NUM_FWD(N), .RADDR_W(A)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .o_In_Ready(in_ready), .i_Flush(flush),
    .i_Rs1_Addr(rs1a), .i_Rs2_Addr(rs2a), .i_Rs1(rs1), .i_Rs2(rs2), .i_Immediate(imm), .i_PC(pc),
    .i_ALU_src1_Ctrl(s1), .i_ALU_src2_Ctrl(s2), .i_Fwd_Valid(fvb), .i_Fwd_Pend(fpb),
    .i_Fwd_Addr(fab), .i_Fwd_Data(fdb), .o_Valid(o_valid), .i_Ready(ready),
    .o_Op1(op1), .o_Op2(op2), .o_Store_Data(sd)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  // Youngest producer (lowest index) with a matching nonzero destination supplies the value.
  function automatic logic [W+1:0] resolve(input logic [A-1:0] a, input logic [W-1:0] rf);
    if (a != 0)
      for (int p = 0; p < N; p++)
        if (fv[p] && fa[p] == a) return {1'b1, fp[p], fd[p]};
    return {2'b00, rf};
  endfunction
  task automatic clr();
    rst = 0; valid = 0; flush = 0; ready = 1; s1 = 0; s2 = 0;
    rs1a = 0; rs2a = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0;
    for (int p = 0; p < N; p++) begin fv[p] = 0; fp[p] = 0; fa[p] = 0; fd[p] = 0; end
  endtask
  task automatic cycle();
    logic [W+1:0] r1, r2;
    logic haz, rdy;
    r1 = resolve(rs1a, rs1);
    r2 = resolve(rs2a, rs2);
    haz = (s1 == 2'b00 && r1[W]) || r2[W];
    rdy = (!m_valid || ready) && !haz;
    #1;
    chk("in_ready", in_ready, rdy);
    if (rst) begin
      m_valid = 0; m_op1 = 0; m_op2 = 0; m_sd = 0;
    end else if (flush) m_valid = 0;
    else if (valid && rdy) begin
      m_valid = 1;
      m_op1 = s1 == 2'b00 ? r1[W-1:0] : s1 == 2'b01 ? pc : '0;
      m_op2 = s2 ? imm : r2[W-1:0];
      m_sd  = r2[W-1:0];
    end else if (ready) m_valid = 0;
    @(posedge clk); #1;
    chk("o_valid", o_valid, m_valid);
    chk("op1", op1, m_op1);
    chk("op2", op2, m_op2);
    chk("store", sd, m_sd);
    @(negedge clk);
  endtask
  initial begin
    clr();
    rst = 1; valid = 1;
    @(posedge clk); #1;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_sd = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_op1", op1, 0);
    @(negedge clk);
    // Two producers match rs1; the younger one wins.
    clr(); valid = 1; rs1a = 3; rs1 = 32'h11;
    fv[0] = 1; fa[0] = 3; fd[0] = 32'hAA; fv[1] = 1; fa[1] = 3; fd[1] = 32'hBB;
    cycle();
    chk("tp1_op1", op1, 32'hAA);
    chk("tp1_valid", o_valid, 1);
    clr(); valid = 1; fv[0] = 1; fa[0] = 0; fd[0] = 32'h55;
    cycle();
    chk("tp2_op2", op2, 0);
    chk("tp2_store", sd, 0);
    // Load-use hazard on rs2 stalls until the producer's data arrives.
    clr(); valid = 1; rs2a = 7; rs1 = 32'h1234; fv[0] = 1; fa[0] = 7; fp[0] = 1;
    cycle();
    chk("tp3_bubble", o_valid, 0);
    cycle();
    fp[0] = 0; fd[0] = 32'h77;
    cycle();
    chk("tp3_store", sd, 32'h77);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; s1 = 2'($urandom); s2 = 1'($urandom);
      cycle();
      chk("hold_op1", op1, 32'h1234);
      chk("hold_op2", op2, 32'h77);
    end
    clr(); valid = 1; s1 = 2'b01; pc = 32'h100; s2 = 1; imm = 32'hFFFF_FFF0; rs2a = 2; rs2 = 32'hCAFE;
    cycle();
    chk("tp5_op1", op1, 32'h100);
    chk("tp5_op2", op2, 32'hFFFF_FFF0);
    chk("tp5_store", sd, 32'hCAFE);
    chk("b2b_valid", o_valid, 1);
    ready = 0; flush = 1;
    cycle();
    chk("flush_valid", o_valid, 0);
    flush = 0; ready = 1;
    cycle();
    rst = 1; valid = 1;
    cycle();
    chk("rst2_op2", op2, 0);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      flush = $urandom_range(0, 19) == 0;
      valid = $urandom_range(0, 3) != 0;
      ready = $urandom_range(0, 3) != 0;
      rs1a = 5'($urandom_range(0, 3)); rs2a = 5'($urandom_range(0, 3));
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; pc = $urandom;
      s1 = 2'($urandom); s2 = 1'($urandom);
      for (int p = 0; p < N; p++) begin
        fv[p] = 1'($urandom); fp[p] = $urandom_range(0, 5) == 0;
        fa[p] = 5'($urandom_range(0, 3)); fd[p] = $urandom;
      end
      cycle();
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
